logic_gate_unit: RTL and testbench
==================================

# logic_gate_unit

Parametrised, registered bitwise logic unit for the board demo. Two WIDTH-bit operand vectors from slide switches are synchronised and debounced. A debounced push-button cycles the unit through six gate functions: AND, OR, XOR, NAND, NOR, XNOR. The registered result drives LEDs. It replaces the single fixed AND gate as the top-level logic block.

## Interface
Parameters:
- WIDTH, 1: bits per operand vector and result.
- SYNC_STAGES, 2: synchroniser flops per raw input (≥2).
- DEBOUNCE_CYCLES, 1000000: consecutive stable cycles required to accept a new input level (10 ms at 100 MHz; ≥1).

Ports:
- clk  in  1  single system clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- A  in  WIDTH  raw switch operand A, asynchronous to clk.
- B  in  WIDTH  raw switch operand B, asynchronous to clk.
- btn_mode  in  1  raw mode push-button, asynchronous, active-high.
- en  in  1  synchronous; 1 = update result, 0 = hold out_y.
- out_y  out  WIDTH  registered result of the selected gate on debounced A, B.
- mode  out  3  current gate code.
- mode_strobe  out  1  one-cycle pulse on every mode change.

## Operation
- Each of the 2·WIDTH+1 raw inputs passes through its own synchroniser and debouncer.
- Debouncer behaviour:
  - Holds a stable value and a counter of width $clog2(DEBOUNCE_CYCLES+1).
  - Synchronised level equals stable value → counter cleared to 0.
  - Levels differ → counter increments.
  - When the counter reaches DEBOUNCE_CYCLES, the stable value takes the synchronised level and the counter clears.
  - A glitch shorter than DEBOUNCE_CYCLES cycles never changes the stable value.
- Mode register codes: AND=0, OR=1, XOR=2, NAND=3, NOR=4, XNOR=5. Codes 6–7 are unreachable; if ever present, the register returns to AND on the next advance.
- A rising edge of the debounced btn_mode advances the mode by one, wrapping XNOR→AND. A held button advances exactly once.
- mode_strobe is high during the cycle after mode updates, i.e. it coincides with the new mode value.
- Each edge with en=1: out_y <= f(mode, A_db, B_db), applied bitwise. en=0 holds out_y; mode still advances.
- Reset asserted at any time forces:
  - all synchroniser flops, stable values and counters to 0;
  - mode = AND (0), out_y = 0, mode_strobe = 0.
- Any partial debounce count is discarded on reset. Outputs hold these values while rst is high.

## Timing
- Input-to-debounced latency: a level first sampled at edge 1 and held becomes the stable value at edge SYNC_STAGES+DEBOUNCE_CYCLES.
- Operand path: out_y reflects a new operand one edge after the debounced value changes.
- Mode path: the mode register updates one edge after the debounced button rises. out_y uses the new mode on the following edge (total button-to-out_y = SYNC_STAGES+DEBOUNCE_CYCLES+2 edges).
- Simultaneous mode advance and operand change: out_y at that edge uses the old mode and the current debounced operands. The next edge uses the new mode.
- Reset deassertion is synchronised externally; no recovery logic inside the block.
- Throughput: one result per cycle when en=1.

## Structure
- Package logic_gate_pkg holds:
  - gate codes MODE_AND..MODE_XNOR;
  - MODE_W=3 and MODE_COUNT=6;
  - a function gate_eval(mode, a, b) returning the bitwise result.
- Sub-module switch_debounce (parameters SYNC_STAGES, DEBOUNCE_CYCLES; ports clk, rst, raw, stable, rise) is instantiated per input bit via generate. Only btn_mode's rise output is used.
- Top-level logic_gate_unit holds the mode register, the strobe, and the output register.

## Test plan
Bench parameters: WIDTH=4, SYNC_STAGES=2, DEBOUNCE_CYCLES=4, en=1 unless stated.
1. Reset: assert rst mid-run with A=4'hF, B=4'hF → out_y=0, mode=0 and mode_strobe=0 immediately (asynchronous) and while held.
2. AND latency: A=4'b1100, B=4'b1010 held from edge 1 → out_y=4'b1000 first at edge 7, not at edge 6.
3. Glitch rejection: A toggled high for 3 cycles then low → debounced A never changes and out_y stays 0.
4. Mode cycling: six clean button presses, each held 10 cycles → mode steps 1,2,3,4,5,0. mode_strobe pulses exactly 6 times. With A=4'b1100, B=4'b1010, out_y reads OR=1110, XOR=0110, NAND=0111, NOR=0001, XNOR=1001, AND=1000.
5. Hold: en=0 while A changes to 4'hF → out_y frozen. Raise en → out_y updates on the next edge.
6. Reset mid-debounce: A rises, rst pulsed after 3 stable cycles → after release, A must be re-held for the full 2+4 edges before out_y changes.

Source files
------------

// File: rtl/logic_gate_pkg.sv
// Shared gate codes and evaluation helpers for the board-demo logic unit.
package logic_gate_pkg;

  localparam int unsigned MODE_W     = 3;
  localparam int unsigned MODE_COUNT = 6;

  typedef enum logic [MODE_W-1:0] {
    MODE_AND  = 3'd0,
    MODE_OR   = 3'd1,
    MODE_XOR  = 3'd2,
    MODE_NAND = 3'd3,
    MODE_NOR  = 3'd4,
    MODE_XNOR = 3'd5
  } gate_mode_e;

  function automatic logic gate_eval(gate_mode_e mode, logic a, logic b);
    logic y;
    case (mode)
      MODE_AND:  y = a & b;
      MODE_OR:   y = a | b;
      MODE_XOR:  y = a ^ b;
      MODE_NAND: y = ~(a & b);
      MODE_NOR:  y = ~(a | b);
      MODE_XNOR: y = ~(a ^ b);
      default:   y = a & b;
    endcase
    return y;
  endfunction

  // Stray codes 6-7 fall back to AND on the next advance.
  function automatic gate_mode_e nextMode(gate_mode_e mode);
    if (int'(mode) >= int'(MODE_COUNT) - 1)
      return MODE_AND;
    return gate_mode_e'(mode + 3'd1);
  endfunction

endpackage

// File: rtl/logic_gate_unit_switch_debounce.sv
// Per-bit synchroniser plus counter debouncer for an asynchronous raw input.
module switch_debounce #(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic stable,
  output logic rise
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic [SYNC_STAGES-1:0] syncQ;
  logic [CNT_W-1:0]       cnt;
  logic                   level;

  assign level = syncQ[SYNC_STAGES-1];

  // Accepting at DEBOUNCE_CYCLES-1 makes the counter's next value DEBOUNCE_CYCLES on that edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      syncQ  <= '0;
      stable <= 1'b0;
      cnt    <= '0;
      rise   <= 1'b0;
    end else begin
      syncQ <= {syncQ[SYNC_STAGES-2:0], raw};
      rise  <= 1'b0;
      if (level == stable) begin
        cnt <= '0;
      end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        stable <= level;
        cnt    <= '0;
        rise   <= level;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/logic_gate_unit.sv
// Registered bitwise logic unit: debounced operands, push-button gate select, LED result.
module logic_gate_unit
  import logic_gate_pkg::*;
#(
  parameter int unsigned WIDTH           = 1,
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             btn_mode,
  input  logic             en,
  output logic [WIDTH-1:0] out_y,
  output logic [2:0]       mode,
  output logic             mode_strobe
);

  logic [WIDTH-1:0] aDb, bDb, gateY;
  logic [WIDTH-1:0] aRiseUnused, bRiseUnused;
  logic             btnStableUnused, btnRise;
  gate_mode_e       modeQ, modeNext;

  for (genvar i = 0; i < WIDTH; i++) begin : gOperand
    switch_debounce #(
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) uDbA (
      .clk    (clk),
      .rst    (rst),
      .raw    (A[i]),
      .stable (aDb[i]),
      .rise   (aRiseUnused[i])
    );
    switch_debounce #(
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) uDbB (
      .clk    (clk),
      .rst    (rst),
      .raw    (B[i]),
      .stable (bDb[i]),
      .rise   (bRiseUnused[i])
    );
  end

  switch_debounce #(
    .SYNC_STAGES     (SYNC_STAGES),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) uDbBtn (
    .clk    (clk),
    .rst    (rst),
    .raw    (btn_mode),
    .stable (btnStableUnused),
    .rise   (btnRise)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      modeQ       <= MODE_AND;
      mode_strobe <= 1'b0;
    end else begin
      modeQ       <= modeNext;
      mode_strobe <= btnRise;
    end
  end

  always_comb begin
    modeNext = modeQ;
    if (btnRise)
      modeNext = nextMode(modeQ);
  end

  always_comb begin
    mode = modeQ;
  end

  always_comb begin
    gateY = '0;
    for (int unsigned i = 0; i < WIDTH; i++)
      gateY[i] = gate_eval(modeQ, aDb[i], bDb[i]);
  end

  // Uses the pre-edge mode, so a simultaneous mode advance takes effect one edge later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      out_y <= '0;
    else if (en)
      out_y <= gateY;
  end

endmodule

// File: tb/tb_logic_gate_unit.sv
// Randomised and directed bench for logic_gate_unit against a window-based reference model.
module tb_logic_gate_unit;

  localparam int WIDTH = 4;
  localparam int SS    = 2;
  localparam int DC    = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [3:0] A, B;
  logic       btnMode;
  logic [3:0] outY;
  logic [2:0] modeOut;
  logic       modeStrobe;

  int checks   = 0;
  int failures = 0;
  int strobeCount;

  logic [8:0] hist[$];
  logic [3:0] mA, mB, mY;
  logic       mBtn, mBtnRose, mStrobe;
  int         mMode;

  always #5 clk = ~clk;

  logic_gate_unit #(
    .WIDTH           (WIDTH),
    .SYNC_STAGES     (SS),
    .DEBOUNCE_CYCLES (DC)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .A           (A),
    .B           (B),
    .btn_mode    (btnMode),
    .en          (en),
    .out_y       (outY),
    .mode        (modeOut),
    .mode_strobe (modeStrobe)
  );

  task automatic checkEq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [3:0] gateRef(int m, logic [3:0] a, logic [3:0] b);
    case (m)
      0: return a & b;
      1: return a | b;
      2: return a ^ b;
      3: return ~(a & b);
      4: return ~(a | b);
      5: return ~(a ^ b);
      default: return 4'h0;
    endcase
  endfunction

  // True when the last DC synchronised samples of this bit all equal level.
  function automatic logic heldWindow(int bitIdx, logic level);
    int n = hist.size();
    for (int j = 0; j < DC; j++) begin
      int idx = n - SS - 1 - j;
      logic v = (idx >= 0) ? hist[idx][bitIdx] : 1'b0;
      if (v !== level) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic modelReset();
    hist.delete();
    mA = '0; mB = '0; mY = '0;
    mBtn = 1'b0; mBtnRose = 1'b0; mStrobe = 1'b0;
    mMode = 0;
  endtask

  task automatic modelEdge();
    logic [3:0] nA, nB;
    logic       nBtn;
    if (en) mY = gateRef(mMode, mA, mB);
    mStrobe = mBtnRose;
    if (mBtnRose) mMode = (mMode + 1) % 6;
    hist.push_back({btnMode, B, A});
    nA = mA; nB = mB; nBtn = mBtn;
    for (int i = 0; i < 4; i++) begin
      if (heldWindow(i, ~mA[i]))     nA[i] = ~mA[i];
      if (heldWindow(i + 4, ~mB[i])) nB[i] = ~mB[i];
    end
    if (heldWindow(8, ~mBtn)) nBtn = ~mBtn;
    mBtnRose = nBtn && !mBtn;
    mA = nA; mB = nB; mBtn = nBtn;
  endtask

  task automatic step();
    @(posedge clk);
    if (!rst) modelEdge();
    #1;
    checkEq("out_y", outY, mY);
    checkEq("mode", modeOut, mMode);
    checkEq("strobe", modeStrobe, mStrobe);
    if (modeStrobe) strobeCount++;
  endtask

  task automatic doReset();
    #2 rst = 1'b1;
    #1;
    modelReset();
    checkEq("rst_async_out", outY, 0);
    checkEq("rst_async_mode", modeOut, 0);
    checkEq("rst_async_strobe", modeStrobe, 0);
    step();
    step();
    checkEq("rst_held_out", outY, 0);
    rst = 1'b0;
  endtask

  initial begin
    logic [3:0] orderOut [6];
    orderOut = '{4'b1110, 4'b0110, 4'b0111, 4'b0001, 4'b1001, 4'b1000};
    rst = 1'b1; en = 1'b1; A = '0; B = '0; btnMode = 1'b0;
    modelReset();
    step(); step();
    rst = 1'b0;

    // AND latency from edge 1
    A = 4'b1100; B = 4'b1010;
    for (int e = 1; e <= 7; e++) begin
      step();
      if (e == 6) checkEq("and_lat_e6", outY, 4'b0000);
      if (e == 7) checkEq("and_lat_e7", outY, 4'b1000);
    end

    // randomised operands, enable and button
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 5) == 0) begin
        A = 4'($urandom);
        B = 4'($urandom);
      end
      if ($urandom_range(0, 15) == 0) en = ~en;
      if ($urandom_range(0, 19) == 0) btnMode = ~btnMode;
      step();
    end
    en = 1'b1; btnMode = 1'b0;

    // reset under all-ones operands
    A = 4'hF; B = 4'hF;
    for (int c = 0; c < 10; c++) step();
    doReset();

    // glitch on A under AND with B all ones
    A = 4'h0; B = 4'hF;
    for (int c = 0; c < 8; c++) step();
    A = 4'hF;
    for (int c = 0; c < 3; c++) step();
    A = 4'h0;
    for (int c = 0; c < 10; c++) begin
      step();
      checkEq("glitch_out", outY, 4'h0);
    end

    // six presses walk through every gate
    doReset();
    A = 4'b1100; B = 4'b1010;
    for (int c = 0; c < 8; c++) step();
    strobeCount = 0;
    for (int p = 0; p < 6; p++) begin
      btnMode = 1'b1;
      for (int c = 0; c < 10; c++) step();
      btnMode = 1'b0;
      for (int c = 0; c < 10; c++) step();
      checkEq("cycle_mode", modeOut, (p + 1) % 6);
      checkEq("cycle_out", outY, orderOut[p]);
    end
    checkEq("strobe_count", strobeCount, 6);

    // en low freezes out_y
    en = 1'b0; A = 4'hF;
    for (int c = 0; c < 12; c++) step();
    checkEq("hold_out", outY, 4'b1000);
    en = 1'b1;
    step();
    checkEq("hold_release", outY, 4'b1010);

    // reset in the middle of a debounce discards the partial count
    doReset();
    A = 4'h0; B = 4'hF;
    for (int c = 0; c < 8; c++) step();
    A = 4'hF;
    for (int c = 0; c < 3; c++) step();
    doReset();
    for (int e = 1; e <= 7; e++) begin
      step();
      if (e == 6) checkEq("rst_db_e6", outY, 4'h0);
      if (e == 7) checkEq("rst_db_e7", outY, 4'hF);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
